// File: rtl/lcd_bus_rx.sv
// Responder for an 8080-style 8-bit LCD write bus. It decodes commands and parameters,
// tracks the CASET/PASET window and emits RGB565 pixels; tearing output via LCD_BUS_RX_FMARK_EN.
module lcd_bus_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int DEFAULT_EC  = 239,
    parameter int DEFAULT_EP  = 319,
    parameter int FMARK_LEN   = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [7:0]  i_lcd_data,
    input  logic        i_lcd_rs,
    input  logic        i_lcd_wr,
    output logic        o_cmd_valid,
    output logic [7:0]  o_cmd,
    output logic        o_param_valid,
    output logic [7:0]  o_param,
    output logic [3:0]  o_param_idx,
    output logic        o_pixel_valid,
    output logic [15:0] o_pixel_data,
    output logic [8:0]  o_pixel_x,
    output logic [8:0]  o_pixel_y,
    output logic        o_frame_start,
    output logic        o_lcd_fmark
);

    localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [1:0] {ST_IDLE, ST_PARAM, ST_PIXEL} state_t;

    // Each stage carries {wr, rs, data}; wr resets high so an idle bus makes no event.
    for (genvar gi = 0; gi < NS; gi++) begin : gen_sync
        logic [9:0] stage_q;
        always_ff @(posedge i_clk) begin
            if (i_reset) begin
                stage_q <= 10'h200;
            end else if (gi == 0) begin
                stage_q <= {i_lcd_wr, i_lcd_rs, i_lcd_data};
            end else begin
                stage_q <= gen_sync[(gi == 0) ? 0 : gi - 1].stage_q;
            end
        end
    end

    logic [9:0] sync_w;
    assign sync_w = gen_sync[NS-1].stage_q;

    logic       wr_prev_q;
    logic       ev_q;
    logic       ev_rs_q;
    logic [7:0] ev_data_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_prev_q <= 1'b1;
            ev_q      <= 1'b0;
            ev_rs_q   <= 1'b0;
            ev_data_q <= 8'h00;
        end else begin
            wr_prev_q <= sync_w[9];
            ev_q      <= sync_w[9] & ~wr_prev_q;
            ev_rs_q   <= sync_w[8];
            ev_data_q <= sync_w[7:0];
        end
    end

    state_t     state_q;
    logic [3:0] idx_q;
    logic [8:0] shadow_s_q;
    logic       shadow_e_hi_q;
    logic [8:0] sc_q, ec_q, sp_q, ep_q;
    logic [8:0] x_q, y_q;
    logic       hi_phase_q;
    logic [7:0] pix_hi_q;
    logic       is_addr_cmd;
    logic [8:0] end_w;

    assign is_addr_cmd = (o_cmd == 8'h2A) || (o_cmd == 8'h2B);
    assign end_w       = {shadow_e_hi_q, ev_data_q};

`ifdef LCD_BUS_RX_FMARK_EN
    localparam int FW = $clog2(FMARK_LEN + 1);
    logic          te_en_q;
    logic [FW-1:0] fmark_cnt_q;
    logic          fmark_q;
    assign o_lcd_fmark = fmark_q;
`else
    assign o_lcd_fmark = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q       <= ST_IDLE;
            idx_q         <= 4'd0;
            shadow_s_q    <= 9'd0;
            shadow_e_hi_q <= 1'b0;
            sc_q          <= 9'd0;
            ec_q          <= 9'(DEFAULT_EC);
            sp_q          <= 9'd0;
            ep_q          <= 9'(DEFAULT_EP);
            x_q           <= 9'd0;
            y_q           <= 9'd0;
            hi_phase_q    <= 1'b1;
            pix_hi_q      <= 8'h00;
            o_cmd_valid   <= 1'b0;
            o_cmd         <= 8'h00;
            o_param_valid <= 1'b0;
            o_param       <= 8'h00;
            o_param_idx   <= 4'd0;
            o_pixel_valid <= 1'b0;
            o_pixel_data  <= 16'h0000;
            o_pixel_x     <= 9'd0;
            o_pixel_y     <= 9'd0;
            o_frame_start <= 1'b0;
`ifdef LCD_BUS_RX_FMARK_EN
            te_en_q       <= 1'b0;
            fmark_cnt_q   <= '0;
            fmark_q       <= 1'b0;
`endif
        end else begin
            o_cmd_valid   <= 1'b0;
            o_param_valid <= 1'b0;
            o_pixel_valid <= 1'b0;
            o_frame_start <= 1'b0;
`ifdef LCD_BUS_RX_FMARK_EN
            fmark_q <= (fmark_cnt_q != '0);
            if (fmark_cnt_q != '0) begin
                fmark_cnt_q <= fmark_cnt_q - 1'b1;
            end
`endif
            if (ev_q && !ev_rs_q) begin
                o_cmd_valid <= 1'b1;
                o_cmd       <= ev_data_q;
                idx_q       <= 4'd0;
                hi_phase_q  <= 1'b1;
                case (ev_data_q)
                    8'h2C: begin
                        x_q     <= sc_q;
                        y_q     <= sp_q;
                        state_q <= ST_PIXEL;
                    end
                    8'h3C:   state_q <= ST_PIXEL;
                    default: state_q <= ST_PARAM;
                endcase
`ifdef LCD_BUS_RX_FMARK_EN
                if (ev_data_q == 8'h35) te_en_q <= 1'b1;
                if (ev_data_q == 8'h34) te_en_q <= 1'b0;
`endif
            end else if (ev_q && state_q == ST_PARAM) begin
                o_param_valid <= 1'b1;
                o_param       <= ev_data_q;
                o_param_idx   <= idx_q;
                if (idx_q != 4'd15) idx_q <= idx_q + 4'd1;
                // Window only moves on the fourth byte and only if it is non-empty.
                if (is_addr_cmd) begin
                    case (idx_q)
                        4'd0: shadow_s_q[8]   <= ev_data_q[0];
                        4'd1: shadow_s_q[7:0] <= ev_data_q;
                        4'd2: shadow_e_hi_q   <= ev_data_q[0];
                        4'd3: begin
                            if (shadow_s_q <= end_w) begin
                                if (o_cmd == 8'h2A) begin
                                    sc_q <= shadow_s_q;
                                    ec_q <= end_w;
                                end else begin
                                    sp_q <= shadow_s_q;
                                    ep_q <= end_w;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end else if (ev_q && state_q == ST_PIXEL) begin
                if (hi_phase_q) begin
                    pix_hi_q   <= ev_data_q;
                    hi_phase_q <= 1'b0;
                end else begin
                    hi_phase_q    <= 1'b1;
                    o_pixel_valid <= 1'b1;
                    o_pixel_data  <= {pix_hi_q, ev_data_q};
                    o_pixel_x     <= x_q;
                    o_pixel_y     <= y_q;
                    o_frame_start <= (x_q == sc_q) && (y_q == sp_q);
`ifdef LCD_BUS_RX_FMARK_EN
                    if (te_en_q && x_q == ec_q && y_q == ep_q) begin
                        fmark_cnt_q <= FW'(FMARK_LEN);
                    end
`endif
                    if (x_q == ec_q) begin
                        x_q <= sc_q;
                        y_q <= (y_q == ep_q) ? sp_q : y_q + 9'd1;
                    end else begin
                        x_q <= x_q + 9'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_lcd_bus_rx.sv
// Directed bench for lcd_bus_rx: drives bus bytes and checks the captured output pulses.
module tb_lcd_bus_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  d   = 8'h00;
    logic        rs  = 1'b1;
    logic        wr  = 1'b1;
    logic        cmd_valid, param_valid, pixel_valid, frame_start, fmark;
    logic [7:0]  cmd, param;
    logic [3:0]  param_idx;
    logic [15:0] pixel_data;
    logic [8:0]  pixel_x, pixel_y;

    lcd_bus_rx dut (
        .i_clk(clk), .i_reset(rst), .i_lcd_data(d), .i_lcd_rs(rs), .i_lcd_wr(wr),
        .o_cmd_valid(cmd_valid), .o_cmd(cmd),
        .o_param_valid(param_valid), .o_param(param), .o_param_idx(param_idx),
        .o_pixel_valid(pixel_valid), .o_pixel_data(pixel_data),
        .o_pixel_x(pixel_x), .o_pixel_y(pixel_y),
        .o_frame_start(frame_start), .o_lcd_fmark(fmark)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] data;
        logic [8:0]  x;
        logic [8:0]  y;
        logic        fs;
    } pix_t;

    pix_t        pix_q[$];
    logic [7:0]  cmd_q[$];
    logic [11:0] par_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          fm_hi = 0;

    always @(negedge clk) begin
        if (pixel_valid) pix_q.push_back({pixel_data, pixel_x, pixel_y, frame_start});
        if (cmd_valid)   cmd_q.push_back(cmd);
        if (param_valid) par_q.push_back({param_idx, param});
        if (fmark)       fm_hi++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic send(input logic r, input logic [7:0] b);
        @(posedge clk); #1;
        rs = r; d = b; wr = 1'b0;
        repeat (3) @(posedge clk);
        #1 wr = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic flush();
        repeat (8) @(posedge clk);
    endtask

    task automatic send_pix(input logic [15:0] p);
        send(1'b1, p[15:8]);
        send(1'b1, p[7:0]);
    endtask

    task automatic expect_cmd(input logic [7:0] c);
        if (cmd_q.size() == 0) check($sformatf("cmd_%h_missing", c), 0, 1);
        else check("cmd", cmd_q.pop_front(), c);
    endtask

    task automatic expect_par(input logic [3:0] idx, input logic [7:0] b);
        if (par_q.size() == 0) check($sformatf("par%0d_missing", idx), 0, 1);
        else check($sformatf("par%0d", idx), par_q.pop_front(), {idx, b});
    endtask

    task automatic expect_pix(input logic [15:0] pd, input int x, input int y, input logic fs);
        pix_t p;
        if (pix_q.size() == 0) begin
            check("pix_missing", 0, 1);
        end else begin
            p = pix_q.pop_front();
            check("pix_data", p.data, pd);
            check($sformatf("pix_xy(%0d,%0d)", x, y), {p.x, p.y}, {9'(x), 9'(y)});
            check("pix_fs", p.fs, fs);
        end
    endtask

    task automatic expect_empty(input string tag);
        check({tag, "_pix_left"}, pix_q.size(), 0);
        check({tag, "_cmd_left"}, cmd_q.size(), 0);
        check({tag, "_par_left"}, par_q.size(), 0);
    endtask

    task automatic send_win(input logic [7:0] c, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
        send(1'b0, c); send(1'b1, b0); send(1'b1, b1); send(1'b1, b2); send(1'b1, b3);
        flush();
        expect_cmd(c);
        expect_par(0, b0); expect_par(1, b1); expect_par(2, b2); expect_par(3, b3);
    endtask

    initial begin
        // 1: reset state, idle bus, first pixel at origin
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_cmd", cmd, 8'h00);
        check("rst_param", {param_idx, param}, 12'h000);
        check("rst_pixel", {pixel_data, pixel_x, pixel_y}, 34'h0);
        check("rst_valids", {cmd_valid, param_valid, pixel_valid, frame_start, fmark}, 5'b0);
        repeat (20) @(posedge clk);
        expect_empty("idle");
        send(1'b0, 8'h2C); send_pix(16'hF800);
        flush();
        expect_cmd(8'h2C);
        expect_pix(16'hF800, 0, 0, 1'b1);

        // 2: 3x2 window at (10..12, 5..6)
        send_win(8'h2A, 8'h00, 8'h0A, 8'h00, 8'h0C);
        send_win(8'h2B, 8'h00, 8'h05, 8'h00, 8'h06);
        send(1'b0, 8'h2C);
        for (int i = 0; i < 6; i++) send_pix((i % 2 == 0) ? 16'hF800 : 16'h07E0);
        flush();
        expect_cmd(8'h2C);
        for (int i = 0; i < 6; i++)
            expect_pix((i % 2 == 0) ? 16'hF800 : 16'h07E0, 10 + i % 3, 5 + i / 3, i == 0);
        expect_empty("win");

        // 3: wrap-around and RAMWRC continuation
        send(1'b0, 8'h2C);
        for (int i = 0; i < 7; i++) send_pix((i % 2 == 0) ? 16'hF800 : 16'h07E0);
        flush();
        expect_cmd(8'h2C);
        for (int i = 0; i < 7; i++)
            expect_pix((i % 2 == 0) ? 16'hF800 : 16'h07E0, 10 + (i % 6) % 3, 5 + (i % 6) / 3,
                       i == 0 || i == 6);
        send(1'b0, 8'h3C); send_pix(16'h1357);
        flush();
        expect_cmd(8'h3C);
        expect_pix(16'h1357, 11, 5, 1'b0);

        // 4: odd byte dropped by a following command
        send(1'b0, 8'h2C); send(1'b1, 8'hAB); send(1'b1, 8'hCD); send(1'b1, 8'hEF);
        send(1'b0, 8'h00);
        flush();
        expect_cmd(8'h2C);
        expect_pix(16'hABCD, 10, 5, 1'b1);
        expect_cmd(8'h00);
        expect_empty("odd");

        // 5: inverted CASET rejected, old 10..12 window kept
        send_win(8'h2A, 8'h00, 8'h10, 8'h00, 8'h05);
        send(1'b0, 8'h2C);
        for (int i = 0; i < 4; i++) send_pix(16'h1234 + 16'(i));
        flush();
        expect_cmd(8'h2C);
        expect_pix(16'h1234, 10, 5, 1'b1);
        expect_pix(16'h1235, 11, 5, 1'b0);
        expect_pix(16'h1236, 12, 5, 1'b0);
        expect_pix(16'h1237, 10, 6, 1'b0);
        expect_empty("badwin");

        // 6: reset between pixel halves, then tearing pulse on a 2x1 window
        send(1'b0, 8'h2C); send(1'b1, 8'hF8);
        flush();
        expect_cmd(8'h2C);
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        send(1'b0, 8'h2C); send_pix(16'h1234);
        flush();
        expect_cmd(8'h2C);
        expect_pix(16'h1234, 0, 0, 1'b1);
        send_win(8'h2A, 8'h00, 8'h00, 8'h00, 8'h01);
        send_win(8'h2B, 8'h00, 8'h00, 8'h00, 8'h00);
        send(1'b0, 8'h35); send(1'b1, 8'h00);
        send(1'b0, 8'h2C); send(1'b1, 8'hAA); send(1'b1, 8'h55);
        fm_hi = 0;
        send(1'b1, 8'h55); send(1'b1, 8'hAA);
        repeat (30) @(posedge clk);
        expect_cmd(8'h35);
        expect_par(0, 8'h00);
        expect_cmd(8'h2C);
        expect_pix(16'hAA55, 0, 0, 1'b1);
        expect_pix(16'h55AA, 1, 0, 1'b0);
`ifdef LCD_BUS_RX_FMARK_EN
        check("fmark_cycles", fm_hi, 16);
`else
        check("fmark_cycles", fm_hi, 0);
`endif
        expect_empty("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
